// File: rtl/grid_pkg.sv
// Shared constants for the level-grid arbiter: grid geometry, cell encodings and FSM states.
package grid_pkg;

   localparam int GRID_W    = 40;
   localparam int GRID_H    = 30;
   localparam int CELL_BITS = 3;
   localparam int ADDR_BITS = 11;

   localparam logic [CELL_BITS-1:0] CELL_EMPTY       = 3'd0;
   localparam logic [CELL_BITS-1:0] CELL_WALL_BRICK  = 3'd1;
   localparam logic [CELL_BITS-1:0] CELL_WALL_STONE  = 3'd2;
   localparam logic [CELL_BITS-1:0] CELL_WALL_METAL  = 3'd3;
   localparam logic [CELL_BITS-1:0] CELL_DOOR        = 3'd4;
   localparam logic [CELL_BITS-1:0] CELL_PICKUP      = 3'd5;

   typedef enum logic [1:0] {
      ST_OPEN   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_DRAIN  = 2'd2
   } grid_state_t;

endpackage

// File: rtl/grid_addr_calc.sv
// Combinational (x,y) -> linear grid RAM address plus an in-range flag.
import grid_pkg::*;

module grid_addr_calc (
   input  logic [5:0]           x,
   input  logic [4:0]           y,
   output logic [ADDR_BITS-1:0] addr,
   output logic                 in_range
);

   generate
      if (GRID_W == 40) begin : g_shift_add
         // y*40 == y*32 + y*8
         assign addr = ADDR_BITS'({y, 5'b0}) + ADDR_BITS'({y, 3'b0}) + ADDR_BITS'(x);
      end else begin : g_mult
         assign addr = ADDR_BITS'(32'(y) * GRID_W + 32'(x));
      end
   endgenerate

   assign in_range = (32'(x) < GRID_W) && (32'(y) < GRID_H);

endmodule

// File: rtl/grid_arbiter.sv
// Shares the single-port level-grid RAM between the level loader, game logic and renderer.
// Build option: define GRID_ARB_FIXED_PRI_EN for fixed game-over-renderer priority (default: round-robin).
//
// state  | meaning
// OPEN   | all requesters served
// LOCKED | loader session active, only loader writes served
// DRAIN  | one cycle for the last loader write to retire
import grid_pkg::*;

module grid_arbiter (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ld_busy,
   input  logic                 ld_write,
   input  logic [5:0]           ld_x,
   input  logic [4:0]           ld_y,
   input  logic [CELL_BITS-1:0] ld_data,
   input  logic                 gm_req,
   input  logic                 gm_we,
   input  logic [5:0]           gm_x,
   input  logic [4:0]           gm_y,
   input  logic [CELL_BITS-1:0] gm_wdata,
   output logic                 gm_ack,
   output logic                 gm_rvalid,
   input  logic                 rd_req,
   input  logic [5:0]           rd_x,
   input  logic [4:0]           rd_y,
   output logic                 rd_ack,
   output logic                 rd_rvalid,
   output logic [CELL_BITS-1:0] rdata,
   output logic                 oob,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [CELL_BITS-1:0] ram_wdata,
   output logic                 ram_wren,
   input  logic [CELL_BITS-1:0] ram_q
);

   grid_state_t state_q, state_d;

   logic [ADDR_BITS-1:0] ld_addr, gm_addr, rd_addr;
   logic                 ld_in, gm_in, rd_in;

   logic gm_elig, rd_elig;
   logic grant_gm, grant_rd;

   logic [ADDR_BITS-1:0] nxt_addr;
   logic [CELL_BITS-1:0] nxt_wdata;
   logic                 nxt_wren, nxt_oob;

   logic p1_gm_rd, p1_rd_rd, p1_oob;
   logic rv_oob;

   grid_addr_calc u_ld_addr (.x(ld_x), .y(ld_y), .addr(ld_addr), .in_range(ld_in));
   grid_addr_calc u_gm_addr (.x(gm_x), .y(gm_y), .addr(gm_addr), .in_range(gm_in));
   grid_addr_calc u_rd_addr (.x(rd_x), .y(rd_y), .addr(rd_addr), .in_range(rd_in));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OPEN:   if (ld_busy)  state_d = ST_LOCKED;
         ST_LOCKED: if (!ld_busy) state_d = ST_DRAIN;
         ST_DRAIN:                state_d = ST_OPEN;
         default:                 state_d = ST_OPEN;
      endcase
   end

   // A requester acked this cycle sits out, so a held req is never granted twice.
   assign gm_elig = gm_req && !gm_ack && (state_q == ST_OPEN) && !ld_write;
   assign rd_elig = rd_req && !rd_ack && (state_q == ST_OPEN) && !ld_write;

`ifdef GRID_ARB_FIXED_PRI_EN
   assign grant_gm = gm_elig;
   assign grant_rd = rd_elig && !gm_elig;
`else
   logic ptr_rd_q;   // 1: renderer wins the next tie

   assign grant_gm = gm_elig && (!rd_elig || !ptr_rd_q);
   assign grant_rd = rd_elig && (!gm_elig ||  ptr_rd_q);

   always_ff @(posedge clock) begin
      if (reset)         ptr_rd_q <= 1'b0;
      else if (grant_gm) ptr_rd_q <= 1'b1;
      else if (grant_rd) ptr_rd_q <= 1'b0;
   end
`endif

   always_comb begin
      nxt_addr  = '0;
      nxt_wdata = '0;
      nxt_wren  = 1'b0;
      nxt_oob   = 1'b0;
      if (ld_write) begin
         nxt_addr  = ld_addr;
         nxt_wdata = ld_data;
         nxt_wren  = ld_in;
      end else if (grant_gm) begin
         nxt_addr  = gm_addr;
         nxt_wdata = gm_we ? gm_wdata : '0;
         nxt_wren  = gm_we && gm_in;
         nxt_oob   = !gm_in;
      end else if (grant_rd) begin
         nxt_addr  = rd_addr;
         nxt_oob   = !rd_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_OPEN;
         gm_ack    <= 1'b0;
         rd_ack    <= 1'b0;
         oob       <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wren  <= 1'b0;
         p1_gm_rd  <= 1'b0;
         p1_rd_rd  <= 1'b0;
         p1_oob    <= 1'b0;
         gm_rvalid <= 1'b0;
         rd_rvalid <= 1'b0;
         rv_oob    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gm_ack    <= grant_gm;
         rd_ack    <= grant_rd;
         oob       <= nxt_oob;
         ram_addr  <= nxt_addr;
         ram_wdata <= nxt_wdata;
         ram_wren  <= nxt_wren;
         p1_gm_rd  <= grant_gm && !gm_we;
         p1_rd_rd  <= grant_rd;
         p1_oob    <= nxt_oob;
         gm_rvalid <= p1_gm_rd;
         rd_rvalid <= p1_rd_rd;
         rv_oob    <= p1_oob;
      end
   end

   // RAM data arrives one cycle after ram_addr, so the return mux is on ram_q directly.
   assign rdata = ((gm_rvalid || rd_rvalid) && !rv_oob) ? ram_q : '0;

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed self-checking bench for grid_arbiter with a behavioural single-port grid RAM.
import grid_pkg::*;

module tb_grid_arbiter;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 ld_busy, ld_write;
   logic [5:0]           ld_x, gm_x, rd_x;
   logic [4:0]           ld_y, gm_y, rd_y;
   logic [CELL_BITS-1:0] ld_data, gm_wdata;
   logic                 gm_req, gm_we, gm_ack, gm_rvalid;
   logic                 rd_req, rd_ack, rd_rvalid;
   logic [CELL_BITS-1:0] rdata;
   logic                 oob;
   logic [ADDR_BITS-1:0] ram_addr;
   logic [CELL_BITS-1:0] ram_wdata;
   logic                 ram_wren;
   logic [CELL_BITS-1:0] ram_q;

   logic                 pl_en;
   logic [ADDR_BITS-1:0] pl_addr;
   logic [CELL_BITS-1:0] pl_data;
   logic [CELL_BITS-1:0] mem [0:2047];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pl_en)         mem[pl_addr]  <= pl_data;
      else if (ram_wren) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
   end

   grid_arbiter dut (
      .clock(clock), .reset(reset),
      .ld_busy(ld_busy), .ld_write(ld_write), .ld_x(ld_x), .ld_y(ld_y), .ld_data(ld_data),
      .gm_req(gm_req), .gm_we(gm_we), .gm_x(gm_x), .gm_y(gm_y), .gm_wdata(gm_wdata),
      .gm_ack(gm_ack), .gm_rvalid(gm_rvalid),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ack(rd_ack), .rd_rvalid(rd_rvalid),
      .rdata(rdata), .oob(oob),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   task automatic idle_inputs();
      ld_busy = 1'b0; ld_write = 1'b0; ld_x = '0; ld_y = '0; ld_data = '0;
      gm_req = 1'b0; gm_we = 1'b0; gm_x = '0; gm_y = '0; gm_wdata = '0;
      rd_req = 1'b0; rd_x = '0; rd_y = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      idle_inputs();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic poke(input int a, input logic [CELL_BITS-1:0] d);
      pl_addr = ADDR_BITS'(a);
      pl_data = d;
      pl_en   = 1'b1;
      @(negedge clock);
      pl_en   = 1'b0;
   endtask

   task automatic test_reset();
      logic [22:0] outs;
      @(negedge clock);
      reset = 1'b1;
      idle_inputs();
      @(negedge clock);
      outs = {gm_ack, gm_rvalid, rd_ack, rd_rvalid, rdata, oob, ram_addr, ram_wdata, ram_wren};
      n_checks++;
      if (outs !== 23'd0) $display("FAIL reset_outputs got=%h exp=0", outs);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      do_reset();
      poke(0, 3'd5);
      gm_req = 1'b1; gm_we = 1'b0; gm_x = 6'd0; gm_y = 5'd0;
      @(negedge clock);
      n_checks++;
      if ({gm_ack, ram_addr, ram_wren, gm_rvalid} !== {1'b1, 11'd0, 1'b0, 1'b0})
         $display("FAIL single_ack ack=%b addr=%0d wren=%b rv=%b exp ack=1 addr=0 wren=0 rv=0",
                  gm_ack, ram_addr, ram_wren, gm_rvalid);
      else n_pass++;
      gm_req = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({gm_rvalid, rdata, gm_ack} !== {1'b1, 3'd5, 1'b0})
         $display("FAIL single_rvalid rv=%b rdata=%0d ack=%b exp rv=1 rdata=5 ack=0",
                  gm_rvalid, rdata, gm_ack);
      else n_pass++;
   endtask

   task automatic test_alternate();
      logic [16:0] got, exp;
      logic        g;
      do_reset();
      poke(1, 3'd3);
      poke(1199, 3'd6);
      gm_req = 1'b1; gm_we = 1'b0; gm_x = 6'd1;  gm_y = 5'd0;
      rd_req = 1'b1; rd_x = 6'd39; rd_y = 5'd29;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         g = (i % 2 == 0);
         got = {gm_ack, rd_ack, ram_addr, gm_rvalid, rd_rvalid};
         if (i == 0)  exp = {1'b1, 1'b0, 11'd1, 1'b0, 1'b0};
         else if (g)  exp = {1'b1, 1'b0, 11'd1, 1'b0, 1'b1};
         else         exp = {1'b0, 1'b1, 11'd1199, 1'b1, 1'b0};
         n_checks++;
         if (got !== exp) $display("FAIL alt_grant[%0d] got=%h exp=%h", i, got, exp);
         else n_pass++;
         if (i > 0) begin
            n_checks++;
            if (rdata !== (g ? 3'd6 : 3'd3))
               $display("FAIL alt_rdata[%0d] got=%0d exp=%0d", i, rdata, g ? 6 : 3);
            else n_pass++;
         end
      end
      gm_req = 1'b0; rd_req = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_loader_lock();
      int bad_wr = 0;
      int early_ack = 0;
      int lat = 0;
      logic [CELL_BITS-1:0] d;
      do_reset();
      ld_busy = 1'b1;
      @(negedge clock);
      gm_req = 1'b1; gm_we = 1'b0; gm_x = 6'd2; gm_y = 5'd0;
      for (int i = 0; i <= 1200; i++) begin
         @(negedge clock);
         if (gm_ack) early_ack++;
         if (i > 0) begin
            d = 3'(i - 1) ^ 3'((i - 1) / 40);
            if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 11'(i - 1), d}) bad_wr++;
         end
         if (i < 1200) begin
            ld_write = 1'b1;
            ld_x     = 6'(i % 40);
            ld_y     = 5'(i / 40);
            ld_data  = 3'(i) ^ 3'(i / 40);
         end else begin
            ld_write = 1'b0;
            ld_busy  = 1'b0;
         end
      end
      n_checks++;
      if (bad_wr !== 0) $display("FAIL lock_write_stream bad_writes=%0d exp=0", bad_wr);
      else n_pass++;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (gm_ack) begin
            lat = c;
            break;
         end
      end
      gm_req = 1'b0;
      n_checks++;
      if (early_ack !== 0) $display("FAIL lock_holdoff acks_during_lock=%0d exp=0", early_ack);
      else n_pass++;
      n_checks++;
      if (lat !== 3) $display("FAIL lock_release_latency got=%0d exp=3 (0 = timeout)", lat);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if ({gm_rvalid, rdata} !== {1'b1, 3'd2})
         $display("FAIL lock_readback rv=%b rdata=%0d exp rv=1 rdata=2", gm_rvalid, rdata);
      else n_pass++;
   endtask

   task automatic test_loader_priority();
      do_reset();
      poke(4, 3'd2);
      ld_write = 1'b1; ld_x = 6'd3; ld_y = 5'd0; ld_data = 3'd5;
      gm_req = 1'b1; gm_we = 1'b0; gm_x = 6'd3; gm_y = 5'd0;
      rd_req = 1'b1; rd_x = 6'd4; rd_y = 5'd0;
      @(negedge clock);
      n_checks++;
      if ({ram_wren, ram_addr, ram_wdata, gm_ack, rd_ack} !== {1'b1, 11'd3, 3'd5, 1'b0, 1'b0})
         $display("FAIL prio_loader_first wren=%b addr=%0d wd=%0d gack=%b rack=%b exp 1/3/5/0/0",
                  ram_wren, ram_addr, ram_wdata, gm_ack, rd_ack);
      else n_pass++;
      ld_write = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({gm_ack, rd_ack, ram_wren, ram_addr} !== {1'b1, 1'b0, 1'b0, 11'd3})
         $display("FAIL prio_game_next gack=%b rack=%b wren=%b addr=%0d exp 1/0/0/3",
                  gm_ack, rd_ack, ram_wren, ram_addr);
      else n_pass++;
      gm_req = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({rd_ack, gm_rvalid, rdata} !== {1'b1, 1'b1, 3'd5})
         $display("FAIL prio_rd_grant rack=%b grv=%b rdata=%0d exp 1/1/5", rd_ack, gm_rvalid, rdata);
      else n_pass++;
      rd_req = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({rd_rvalid, rdata} !== {1'b1, 3'd2})
         $display("FAIL prio_rd_data rrv=%b rdata=%0d exp 1/2", rd_rvalid, rdata);
      else n_pass++;
   endtask

   task automatic test_oob();
      do_reset();
      poke(1205, 3'd7);
      gm_req = 1'b1; gm_we = 1'b1; gm_x = 6'd40; gm_y = 5'd3; gm_wdata = 3'd7;
      @(negedge clock);
      n_checks++;
      if ({gm_ack, oob, ram_wren} !== {1'b1, 1'b1, 1'b0})
         $display("FAIL oob_gm_write ack=%b oob=%b wren=%b exp 1/1/0", gm_ack, oob, ram_wren);
      else n_pass++;
      gm_req = 1'b0; gm_we = 1'b0;
      rd_req = 1'b1; rd_x = 6'd5; rd_y = 5'd30;
      @(negedge clock);
      n_checks++;
      if ({rd_ack, oob, gm_rvalid} !== {1'b1, 1'b1, 1'b0})
         $display("FAIL oob_rd_ack ack=%b oob=%b grv=%b exp 1/1/0", rd_ack, oob, gm_rvalid);
      else n_pass++;
      rd_req = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({rd_rvalid, rdata, oob} !== {1'b1, 3'd0, 1'b0})
         $display("FAIL oob_rd_data rv=%b rdata=%0d oob=%b exp 1/0/0", rd_rvalid, rdata, oob);
      else n_pass++;
   endtask

   task automatic test_write_then_read();
      do_reset();
      poke(7, 3'd1);
      gm_req = 1'b1; gm_we = 1'b1; gm_x = 6'd7; gm_y = 5'd0; gm_wdata = 3'd3;
      rd_req = 1'b1; rd_x = 6'd7; rd_y = 5'd0;
      @(negedge clock);
      n_checks++;
      if ({gm_ack, ram_wren, ram_addr, ram_wdata, oob} !== {1'b1, 1'b1, 11'd7, 3'd3, 1'b0})
         $display("FAIL wr_rd_write ack=%b wren=%b addr=%0d wd=%0d oob=%b exp 1/1/7/3/0",
                  gm_ack, ram_wren, ram_addr, ram_wdata, oob);
      else n_pass++;
      gm_req = 1'b0; gm_we = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({rd_ack, ram_wren, gm_rvalid} !== {1'b1, 1'b0, 1'b0})
         $display("FAIL wr_rd_read_ack ack=%b wren=%b grv=%b exp 1/0/0", rd_ack, ram_wren, gm_rvalid);
      else n_pass++;
      rd_req = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({rd_rvalid, rdata} !== {1'b1, 3'd3})
         $display("FAIL wr_rd_data rv=%b rdata=%0d exp 1/3", rd_rvalid, rdata);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [22:0] outs;
      do_reset();
      poke(6, 3'd4);
      rd_req = 1'b1; rd_x = 6'd6; rd_y = 5'd0;
      @(negedge clock);
      n_checks++;
      if (rd_ack !== 1'b1) $display("FAIL rstmid_rd_ack got=%b exp=1", rd_ack);
      else n_pass++;
      reset = 1'b1; rd_req = 1'b0;
      @(negedge clock);
      outs = {gm_ack, gm_rvalid, rd_ack, rd_rvalid, rdata, oob, ram_addr, ram_wdata, ram_wren};
      n_checks++;
      if (outs !== 23'd0) $display("FAIL rstmid_outputs got=%h exp=0", outs);
      else n_pass++;
      reset = 1'b0;
      gm_req = 1'b1; gm_we = 1'b0; gm_x = 6'd0; gm_y = 5'd0;
      @(negedge clock);
      n_checks++;
      if ({gm_ack, rd_rvalid} !== {1'b1, 1'b0})
         $display("FAIL rstmid_open ack=%b rrv=%b exp 1/0", gm_ack, rd_rvalid);
      else n_pass++;
      gm_req = 1'b0;
      @(negedge clock);
      ld_busy = 1'b1;
      @(negedge clock);
      reset = 1'b1; ld_busy = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      gm_req = 1'b1;
      @(negedge clock);
      n_checks++;
      if (gm_ack !== 1'b1) $display("FAIL rstmid_locked_to_open ack=%b exp=1", gm_ack);
      else n_pass++;
      gm_req = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      idle_inputs();
      repeat (2) @(negedge clock);
      test_reset();
      test_single_read();
      test_alternate();
      test_loader_lock();
      test_loader_priority();
      test_oob();
      test_write_then_read();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
